mode_ctrl: RTL and testbench

//   Sequencer for the counter's mode-select stage. Turns two raw push-buttons into

---
 rtl/counter_pkg.sv | 33 +++
 rtl/btn_cond.sv | 78 +++++++
 rtl/mode_ctrl.sv | 137 +++++++++++++
 tb/tb_mode_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter's mode-select path: mode encodings used by
// modeselect and mode_ctrl, the mode_ctrl FSM state type, and small mode helpers.
package counter_pkg;

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_CARRY = 2'b01;
  localparam logic [1:0] MODE_MAX   = 2'b10;

  typedef enum logic [1:0] {
    S_FREE  = 2'b00,
    S_CARRY = 2'b01,
    S_MAX   = 2'b10,
    S_ACK   = 2'b11
  } state_t;

  // Button press cycles FREE -> CARRY -> MAX -> FREE.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_FREE:  next_mode = MODE_CARRY;
      MODE_CARRY: next_mode = MODE_MAX;
      default:    next_mode = MODE_FREE;
    endcase
  endfunction

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      MODE_CARRY: mode_state = S_CARRY;
      MODE_MAX:   mode_state = S_MAX;
      default:    mode_state = S_FREE;
    endcase
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw push-button conditioner: 2-flop synchroniser, optional debounce
// (BTN_DEBOUNCE_EN), and a rising-edge detector producing a 1-cycle event.
module btn_cond #(
  parameter int DEB_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic event_o
);

  if (DEB_W < 1) begin : g_bad_deb_w
    $error("btn_cond: DEB_W must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] DEB_LAST = '1;

  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;
  logic             lvl_q;
  logic             lvl_d;

  // Level follows the synchronised input only after 2**DEB_W disagreeing
  // cycles in a row; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync2_q != lvl_q) begin
      if (cnt_q == DEB_LAST) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign level = lvl_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign event_o = level & ~prev_q;

endmodule

// File: rtl/mode_ctrl.sv
// Mode-select sequencer: steps FREE->CARRY->MAX on button presses, waits for
// modeselect feedback, and issues refresh_limits pulses. Optional BTN_DEBOUNCE_EN.
module mode_ctrl
  import counter_pkg::*;
#(
  parameter int DEB_W  = 4,
  parameter int ACK_TO = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_refresh,
  input  logic       carry_en,
  input  logic       max_en,
  output logic       carry_set,
  output logic       max_set,
  output logic       refresh_limits,
  output logic [1:0] mode,
  output logic       busy,
  output logic       mode_err,
  output state_t     dbg_state
);

  localparam int               TMR_W   = $clog2(ACK_TO + 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(ACK_TO);

  logic mode_ev;
  logic ref_ev;

  btn_cond #(.DEB_W(DEB_W)) u_btn_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_mode),
    .event_o (mode_ev)
  );

  btn_cond #(.DEB_W(DEB_W)) u_btn_refresh (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_refresh),
    .event_o (ref_ev)
  );

  state_t           state_q, state_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       mode_q, mode_d;
  logic             carry_set_q, carry_set_d;
  logic             max_set_q, max_set_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic ack;
  logic fire;

  // Handshake: carry_set/max_set are levels held for the target mode; the change
  // is acknowledged once {max_en,carry_en} equals the target encoding.
  assign ack  = ({max_en, carry_en} == tgt_q);
  assign fire = pending_q && (state_q != S_ACK);

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    mode_d      = mode_q;
    carry_set_d = carry_set_q;
    max_set_d   = max_set_q;
    busy_d      = busy_q;
    err_d       = err_q;
    timer_d     = timer_q;
    pending_d   = ref_ev | (pending_q & ~fire);

    case (state_q)
      S_FREE, S_CARRY, S_MAX: begin
        if (mode_ev) begin
          tgt_d       = next_mode(mode_q);
          carry_set_d = (tgt_d == MODE_CARRY);
          max_set_d   = (tgt_d == MODE_MAX);
          busy_d      = 1'b1;
          timer_d     = '0;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        if (ack) begin
          state_d = mode_state(tgt_q);
          mode_d  = tgt_q;
          busy_d  = 1'b0;
        end else if (timer_q == TMR_END) begin
          // No feedback in time: flag it and commit the target anyway.
          err_d   = 1'b1;
          state_d = mode_state(tgt_q);
          mode_d  = tgt_q;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FREE;
      tgt_q       <= MODE_FREE;
      mode_q      <= MODE_FREE;
      carry_set_q <= 1'b0;
      max_set_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      pending_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      mode_q      <= mode_d;
      carry_set_q <= carry_set_d;
      max_set_q   <= max_set_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
    end
  end

  assign carry_set      = carry_set_q;
  assign max_set        = max_set_q;
  assign refresh_limits = fire;
  assign mode           = mode_q;
  assign busy           = busy_q;
  assign mode_err       = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against a cycle-level behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_mode_ctrl;
  import counter_pkg::*;

  localparam int DEB_W  = 2;
  localparam int ACK_TO = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_refresh = 1'b0;
  logic       carry_en = 1'b0;
  logic       max_en = 1'b0;
  logic       carry_set, max_set, refresh_limits, busy, mode_err;
  logic [1:0] mode;
  state_t     dbg_state;
  logic       stuck = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mode_ctrl #(.DEB_W(DEB_W), .ACK_TO(ACK_TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_mode       (btn_mode),
    .btn_refresh    (btn_refresh),
    .carry_en       (carry_en),
    .max_en         (max_en),
    .carry_set      (carry_set),
    .max_set        (max_set),
    .refresh_limits (refresh_limits),
    .mode           (mode),
    .busy           (busy),
    .mode_err       (mode_err),
    .dbg_state      (dbg_state)
  );

  // modeselect stand-in: feedback follows the request one cycle later unless stuck
  always @(posedge clk) begin
    if (reset) begin
      carry_en <= 1'b0;
      max_en   <= 1'b0;
    end else begin
      carry_en <= stuck ? 1'b0 : carry_set;
      max_en   <= stuck ? 1'b0 : max_set;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button raw history: bit0 = sample at previous edge, bit1 = two edges ago, ...
  logic [2:0] hist_m = '0, hist_r = '0;
  int  m_mode = 0, m_tgt = 0, m_wait = 0;
  bit  m_busy = 0, m_err = 0, m_pend = 0, m_cs = 0, m_ms = 0;
  bit  ev_m, ev_r, m_fire;
  int  fb;
`ifdef BTN_DEBOUNCE_EN
  bit  lv_m = 0, pv_m = 0, lv_r = 0, pv_r = 0;
  int  run_m = 0, run_r = 0;
`endif

  always @(posedge clk) begin
`ifdef BTN_DEBOUNCE_EN
    ev_m = lv_m && !pv_m;
    ev_r = lv_r && !pv_r;
    pv_m = lv_m;
    pv_r = lv_r;
    if (hist_m[1] != lv_m) begin
      run_m++;
      if (run_m == (1 << DEB_W)) begin lv_m = hist_m[1]; run_m = 0; end
    end else run_m = 0;
    if (hist_r[1] != lv_r) begin
      run_r++;
      if (run_r == (1 << DEB_W)) begin lv_r = hist_r[1]; run_r = 0; end
    end else run_r = 0;
`else
    // Input seen two edges ago high, three edges ago low: rising edge arrives now.
    ev_m = hist_m[1] && !hist_m[2];
    ev_r = hist_r[1] && !hist_r[2];
`endif
    if (reset) begin
      m_mode = 0; m_tgt = 0; m_wait = 0;
      m_busy = 0; m_err = 0; m_pend = 0; m_cs = 0; m_ms = 0;
      hist_m = '0; hist_r = '0;
`ifdef BTN_DEBOUNCE_EN
      lv_m = 0; pv_m = 0; lv_r = 0; pv_r = 0; run_m = 0; run_r = 0;
`endif
    end else begin
      m_fire = m_pend && !m_busy;
      fb = {30'd0, max_en, carry_en};
      if (!m_busy) begin
        if (ev_m) begin
          m_tgt  = (m_mode + 1) % 3;
          m_cs   = (m_tgt == 1);
          m_ms   = (m_tgt == 2);
          m_busy = 1;
          m_wait = 0;
        end
      end else if (fb == m_tgt) begin
        m_mode = m_tgt;
        m_busy = 0;
      end else if (m_wait == ACK_TO) begin
        m_err  = 1;
        m_mode = m_tgt;
        m_busy = 0;
      end else begin
        m_wait++;
      end
      m_pend = ev_r || (m_pend && !m_fire);
      hist_m = {hist_m[1:0], btn_mode};
      hist_r = {hist_r[1:0], btn_refresh};
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int  pulse_cnt = 0, busy_pulse_cnt = 0, after_ack_cnt = 0, mode_chg_cnt = 0;
  bit  prev_busy = 0;
  logic [1:0] prev_mode = 2'b00;

  always @(negedge clk) begin
    check("carry_set", carry_set, m_cs);
    check("max_set", max_set, m_ms);
    check("mode", mode, m_mode[1:0]);
    check("busy", busy, m_busy);
    check("mode_err", mode_err, m_err);
    check("refresh_limits", refresh_limits, m_pend && !m_busy);
    check("ack_state", dbg_state == S_ACK, m_busy);
    check("set_exclusive", carry_set & max_set, 1'b0);
    if (refresh_limits === 1'b1) begin
      pulse_cnt++;
      if (busy === 1'b1) busy_pulse_cnt++;
      if (prev_busy) after_ack_cnt++;
    end
    if (mode !== prev_mode) mode_chg_cnt++;
    prev_busy = (busy === 1'b1);
    prev_mode = mode;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic val, input int budget);
    for (int i = 0; i < budget && busy !== val; i++) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    btn_mode = 1'b0;
    btn_refresh = 1'b0;
    reset = 1'b1;
    cycles(n);
    reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  int p0, a0, b0, c0;

  initial begin
    // 1: reset held, buttons idle
    reset = 1'b1;
    cycles(5);
    check("t1_carry_set", carry_set, 1'b0);
    check("t1_max_set", max_set, 1'b0);
    check("t1_mode", mode, 2'b00);
    check("t1_busy_err", {busy, mode_err, refresh_limits}, 3'b000);
    reset = 1'b0;
    p0 = pulse_cnt;
    cycles(6);
    check("t1_no_pulse", pulse_cnt - p0, 0);

    // 2: three presses walk the modes
    btn_mode = 1'b1;
    wait_busy(1'b1, 30);
    check("t2_busy", busy, 1'b1);
    check("t2_carry_req", {max_set, carry_set}, 2'b01);
    wait_busy(1'b0, 30);
    check("t2_mode_carry", mode, 2'b01);
    cycles(4);
    btn_mode = 1'b0;
    cycles(8);
    btn_mode = 1'b1;
    wait_busy(1'b1, 30);
    check("t2_swap", {max_set, carry_set}, 2'b10);
    wait_busy(1'b0, 30);
    check("t2_mode_max", mode, 2'b10);
    cycles(4);
    btn_mode = 1'b0;
    cycles(8);
    btn_mode = 1'b1;
    wait_busy(1'b1, 30);
    check("t2_free_req", {max_set, carry_set}, 2'b00);
    wait_busy(1'b0, 30);
    check("t2_mode_free", mode, 2'b00);
    btn_mode = 1'b0;
    cycles(8);

    // 3: mode + two refresh presses -> one pulse, right after the ack
    p0 = pulse_cnt; a0 = after_ack_cnt; b0 = busy_pulse_cnt;
    btn_mode = 1'b1; btn_refresh = 1'b1;
    cycles(1);
    btn_refresh = 1'b0;
    cycles(1);
    btn_refresh = 1'b1;
    cycles(1);
    btn_refresh = 1'b0;
    cycles(4);
    btn_mode = 1'b0;
    cycles(10);
    check("t3_one_pulse", pulse_cnt - p0, 1);
    check("t3_after_ack", after_ack_cnt - a0, 1);
    check("t3_none_in_ack", busy_pulse_cnt - b0, 0);
    check("t3_mode", mode, 2'b01);

    // 4: feedback stuck -> sticky error
    do_reset(2);
    stuck = 1'b1;
    btn_mode = 1'b1;
    for (int i = 0; i < 40 && mode_err !== 1'b1; i++) @(negedge clk);
    check("t4_err", mode_err, 1'b1);
    check("t4_mode", mode, 2'b01);
    btn_mode = 1'b0;
    cycles(6);
    btn_mode = 1'b1;
    wait_busy(1'b1, 30);
    wait_busy(1'b0, 30);
    check("t4_err_sticky", mode_err, 1'b1);
    check("t4_mode_max", mode, 2'b10);
    btn_mode = 1'b0;
    stuck = 1'b0;
    do_reset(1);
    check("t4_err_cleared", mode_err, 1'b0);

    // 5: button chatter every cycle
    cycles(4);
    c0 = mode_chg_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_mode = ~btn_mode;
      cycles(1);
    end
    btn_mode = 1'b0;
    cycles(20);
`ifdef BTN_DEBOUNCE_EN
    check("t5_chatter_changes", mode_chg_cnt - c0, 0);
`else
    check("t5_chatter_changes", mode_chg_cnt - c0, 3);
`endif

    // 6: reset while waiting for ack, with a refresh pending
    do_reset(1);
    cycles(2);
    btn_mode = 1'b1; btn_refresh = 1'b1;
    wait_busy(1'b1, 30);
    check("t6_in_ack", busy, 1'b1);
    do_reset(1);
    check("t6_abort", {carry_set, max_set, busy, refresh_limits}, 4'b0000);
    check("t6_mode", mode, 2'b00);
    p0 = pulse_cnt;
    cycles(10);
    check("t6_pending_cleared", pulse_cnt - p0, 0);

    // random traffic: chatter, holds, stuck feedback, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_refresh = ~btn_refresh;
      if ($urandom_range(0, 149) == 0) stuck = ~stuck;
      reset = ($urandom_range(0, 399) == 0);
      cycles(1);
    end
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_refresh = 1'b0;
    cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
